// File: rtl/alu_nibble_adder.sv
// Nibble-serial 6502 adder: latches operands, then forms the low and high nibble sums on successive cycles.
// Decimal carry detection and the daa/dsa controls are compiled in only when ALU_DECIMAL_MODE_EN is defined.
module alu_nibble_adder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] ai,
  input  logic [7:0] bi,
  input  logic       cin,
  input  logic       sub,
  input  logic       dec,
  input  logic       ack,
  output logic       busy,
  output logic       valid,
  output logic [7:0] add,
  output logic       hc,
  output logic       acr,
  output logic       avr,
  output logic       daa,
  output logic       dsa
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t      r_state;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic        r_cin;
  logic        r_sub;
  logic        r_dec;
  logic        r_busy;
  logic        r_valid;
  logic [7:0]  r_add;
  logic        r_hc;
  logic        r_acr;
  logic        r_avr;
  logic        r_daa;
  logic        r_dsa;

  logic        w_dec;
  logic        w_bcd_add;
  logic        w_load;
  logic [4:0]  w_s_lo;
  logic [4:0]  w_s_hi;

  // BCD add flags a nibble sum above 9 as a decimal carry; otherwise the binary carry is used.
  function automatic logic nib_carry(input logic [4:0] s, input logic bcd);
    return bcd ? (s > 5'd9) : s[4];
  endfunction

`ifdef ALU_DECIMAL_MODE_EN
  assign w_dec = dec;
`else
  logic w_dec_unused;
  assign w_dec_unused = dec;
  assign w_dec        = 1'b0;
`endif

  assign w_bcd_add = r_dec & ~r_sub;
  assign w_load    = start & ((r_state == S_IDLE) | ((r_state == S_DONE) & ack));
  assign w_s_lo    = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0, r_cin};
  assign w_s_hi    = {1'b0, r_a[7:4]} + {1'b0, r_b[7:4]} + {4'b0, r_hc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= 8'h00;
      r_b     <= 8'h00;
      r_cin   <= 1'b0;
      r_sub   <= 1'b0;
      r_dec   <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_add   <= 8'h00;
      r_hc    <= 1'b0;
      r_acr   <= 1'b0;
      r_avr   <= 1'b0;
      r_daa   <= 1'b0;
      r_dsa   <= 1'b0;
    end else begin
      if (w_load) begin
        r_a   <= ai;
        r_b   <= sub ? ~bi : bi;
        r_cin <= cin;
        r_sub <= sub;
        r_dec <= w_dec;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy  <= 1'b1;
            r_state <= S_LO;
          end
        end
        S_LO: begin
          r_add[3:0] <= w_s_lo[3:0];
          r_hc       <= nib_carry(w_s_lo, w_bcd_add);
          r_state    <= S_HI;
        end
        S_HI: begin
          r_add[7:4] <= w_s_hi[3:0];
          r_acr      <= nib_carry(w_s_hi, w_bcd_add);
          r_avr      <= (r_a[7] ~^ r_b[7]) & (r_a[7] ^ w_s_hi[3]);
          r_daa      <= r_dec & ~r_sub;
          r_dsa      <= r_dec & r_sub;
          r_valid    <= 1'b1;
          r_state    <= S_DONE;
        end
        S_DONE: begin
          // Results hold until the consumer acks; ack with start chains straight into the next add.
          if (ack) begin
            r_valid <= 1'b0;
            if (start) begin
              r_state <= S_LO;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy  = r_busy;
  assign valid = r_valid;
  assign add   = r_add;
  assign hc    = r_hc;
  assign acr   = r_acr;
  assign avr   = r_avr;
  assign daa   = r_daa;
  assign dsa   = r_dsa;

endmodule

// File: tb/tb_alu_nibble_adder.sv
// Bench for alu_nibble_adder: directed vectors, handshake and reset cases, then randomized operations.
// Expected results come from a nibble arithmetic model; decimal behaviour follows ALU_DECIMAL_MODE_EN.
module tb_alu_nibble_adder;

`ifdef ALU_DECIMAL_MODE_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] ai = 8'h00;
  logic [7:0] bi = 8'h00;
  logic       cin = 1'b0;
  logic       sub = 1'b0;
  logic       dec = 1'b0;
  logic       ack = 1'b0;
  logic       busy, valid, hc, acr, avr, daa, dsa;
  logic [7:0] add;

  int n_checks = 0;
  int n_fail   = 0;
  logic [12:0] exp_vec = 13'h0;
  bit in_done = 1'b0;

  alu_nibble_adder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ai(ai), .bi(bi), .cin(cin),
    .sub(sub), .dec(dec), .ack(ack), .busy(busy), .valid(valid), .add(add),
    .hc(hc), .acr(acr), .avr(avr), .daa(daa), .dsa(dsa)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Result packed as {add[7:0], hc, acr, avr, daa, dsa}.
  function automatic logic [12:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic c, input logic s, input logic d);
    logic [7:0] bb;
    int lo, hi;
    logic de, bcd, h, cr, v;
    de  = DEC_EN & d;
    bcd = de & ~s;
    bb  = s ? ~b : b;
    lo  = int'(a[3:0]) + int'(bb[3:0]) + int'(c);
    h   = bcd ? (lo > 9) : (lo > 15);
    hi  = int'(a[7:4]) + int'(bb[7:4]) + int'(h);
    cr  = bcd ? (hi > 9) : (hi > 15);
    v   = (a[7] == bb[7]) && (a[7] != hi[3]);
    return {hi[3:0], lo[3:0], h, cr, v, de & ~s, de & s};
  endfunction

  always @(negedge clk) begin
    if (rst_n && valid) begin
      chk("busy_in_done", 16'(busy), 16'd1);
      chk("add", 16'(add), 16'(exp_vec[12:5]));
      chk("flags_hc_acr_avr_daa_dsa", 16'({hc, acr, avr, daa, dsa}), 16'(exp_vec[4:0]));
    end
  end

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic s, input logic d, input logic b2b);
    int n;
    @(negedge clk); #1;
    ai = a; bi = b; cin = c; sub = s; dec = d; start = 1'b1; ack = b2b;
    exp_vec = model(a, b, c, s, d);
    @(posedge clk); #1;
    ack = 1'b0;
    start = 1'($urandom_range(0, 1));
    ai = 8'($urandom); bi = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom); dec = 1'($urandom);
    chk("latch_busy_valid", 16'({busy, valid}), 16'b10);
    @(posedge clk); #1;
    chk("hc_early", 16'(hc), 16'(exp_vec[4]));
    n = 0;
    while (!valid && n < 6) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 16'(n), 16'd1);
    start = 1'b0;
    in_done = 1'b1;
  endtask

  task automatic retire();
    @(negedge clk); #1;
    ack = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    ack = 1'b0;
    chk("retire_busy_valid", 16'({busy, valid}), 16'b00);
    in_done = 1'b0;
  endtask

  task automatic hold(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk); #1;
      start = 1'($urandom_range(0, 1));
      ai = 8'($urandom); bi = 8'($urandom); sub = 1'($urandom); dec = 1'($urandom);
    end
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 16'({busy, valid, add, hc, acr, avr, daa, dsa}), 16'h0);
    @(negedge clk); rst_n = 1'b1;

    chk("model_bin_add", 16'(model(8'h50, 8'h50, 1'b0, 1'b0, 1'b0)), 16'({8'hA0, 5'b00100}));
    chk("model_bcd_sub", 16'(model(8'h10, 8'h01, 1'b1, 1'b1, 1'b1)), 16'({8'h0F, 4'b0100, DEC_EN}));

    do_op(8'h50, 8'h50, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_add", 16'(add), 16'h00A0);
    chk("t1_flags", 16'({hc, acr, avr, daa, dsa}), 16'b00100);
    retire();

    do_op(8'h09, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2_add", 16'(add), DEC_EN ? 16'h001A : 16'h000A);
    chk("t2_flags", 16'({hc, acr, avr, daa, dsa}), DEC_EN ? 16'b10010 : 16'b00000);
    retire();

    do_op(8'h99, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_add", 16'(add), DEC_EN ? 16'h00AA : 16'h009A);
    chk("t3_flags", 16'({hc, acr, avr, daa, dsa}), DEC_EN ? 16'b11010 : 16'b00000);
    retire();

    do_op(8'h10, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t4_add", 16'(add), 16'h000F);
    chk("t4_flags", 16'({hc, acr, avr, daa, dsa}), DEC_EN ? 16'b01001 : 16'b01000);
    hold(5);
    chk("t5_hold_add", 16'(add), 16'h000F);
    chk("t5_hold_valid", 16'({busy, valid}), 16'b11);
    do_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5_b2b_add", 16'(add), 16'h0002);
    retire();

    @(negedge clk); #1;
    ai = 8'h37; bi = 8'h25; cin = 1'b0; sub = 1'b0; dec = 1'b0; start = 1'b1;
    exp_vec = model(8'h37, 8'h25, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    chk("t6_pre_reset_add_lo", 16'(add[3:0]), 16'h000C);
    #2 rst_n = 1'b0;
    #1 chk("t6_async_reset", 16'({busy, valid, add, hc, acr, avr, daa, dsa}), 16'h0);
    @(posedge clk); #1;
    chk("t6_reset_held", 16'({busy, valid, add, hc, acr, avr, daa, dsa}), 16'h0);
    @(negedge clk); rst_n = 1'b1;
    in_done = 1'b0;
    do_op(8'h03, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_after_reset_add", 16'(add), 16'h0007);
    retire();

    for (int i = 0; i < 150; i++) begin
      logic b2b;
      b2b = 1'b0;
      if (in_done) begin
        if ($urandom_range(0, 1) == 1) b2b = 1'b1;
        else retire();
      end
      do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), b2b);
      hold(int'($urandom_range(0, 2)));
    end
    if (in_done) retire();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d checks done", n_checks);
    $fatal(1, "timeout");
  end

endmodule
